// File: rtl/computie_ad_bus.sv
// Multiplexed AD bus master: address beats (MS first), turnaround, DS/DTACK data phase, timeout.
// Accept->resp_valid = ADDR_BEATS+1+N_data edges; req_ready only in IDLE, one transaction in flight.
module computie_ad_bus #(
    parameter int AD_WIDTH       = 16,
    parameter int ADDR_BEATS     = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic                           req_write,
    input  logic [AD_WIDTH*ADDR_BEATS-1:0] req_addr,
    input  logic [AD_WIDTH-1:0]            req_wdata,
    output logic                           resp_valid,
    output logic                           resp_error,
    output logic [AD_WIDTH-1:0]            resp_rdata,
    inout  wire  [AD_WIDTH-1:0]            pins_ad,
    output logic                           bus_ale,
    output logic                           bus_ds_n,
    output logic                           bus_rw,
    input  logic                           bus_dtack_n
);
    localparam int AW = AD_WIDTH * ADDR_BEATS;
    localparam int BW = (ADDR_BEATS > 1) ? $clog2(ADDR_BEATS) : 1;
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(ADDR_BEATS - 1);
    localparam logic [CW-1:0] TMO_LAST  = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_TURN,
        S_DATA,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [BW-1:0]       beat_q, beat_d;
    logic [CW-1:0]       tmo_q, tmo_d;
    logic                write_q, write_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [AD_WIDTH-1:0] wdata_q, wdata_d;
    logic                error_q, error_d;
    logic [AD_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]          dtack_sync_q, dtack_sync_d;
    logic                dtack_s;
    logic [AD_WIDTH-1:0] addr_beat;

    // IO register stage: these flops pack into the SB_IO output/OE/input registers,
    // so every bus pin lags the FSM by exactly one cycle and stays mutually aligned.
    logic [AD_WIDTH-1:0] ad_out_q, ad_out_d;
    logic [AD_WIDTH-1:0] ad_in_q, ad_in_d;
    logic                ad_oe_q, ad_oe_d;
    logic                ale_q, ale_d;
    logic                ds_n_q, ds_n_d;
    logic                rw_q, rw_d;

    assign dtack_s      = dtack_sync_q[1];
    assign dtack_sync_d = {dtack_sync_q[0], bus_dtack_n};
    assign ad_in_d      = pins_ad;
    assign addr_beat    = AD_WIDTH'(addr_q >> (AD_WIDTH * (ADDR_BEATS - 1 - int'(beat_q))));

    assign pins_ad    = ad_oe_q ? ad_out_q : {AD_WIDTH{1'bz}};
    assign bus_ale    = ale_q;
    assign bus_ds_n   = ds_n_q;
    assign bus_rw     = rw_q;
    assign resp_error = resp_valid & error_q;
    assign resp_rdata = rdata_q;

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        tmo_d      = tmo_q;
        write_d    = write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        error_d    = error_q;
        rdata_d    = rdata_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        ad_oe_d    = 1'b0;
        ad_out_d   = '0;
        ale_d      = 1'b0;
        ds_n_d     = 1'b1;
        rw_d       = 1'b1;

        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    beat_d  = '0;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                ad_oe_d  = 1'b1;
                ad_out_d = addr_beat;
                ale_d    = 1'b1;
                rw_d     = ~write_q;
                beat_d   = beat_q + BW'(1);
                if (beat_q == LAST_BEAT) begin
                    state_d = S_TURN;
                end
            end
            S_TURN: begin
                // Reads release the bus here so the target can drive it during DATA.
                ad_oe_d  = write_q;
                ad_out_d = write_q ? wdata_q : '0;
                rw_d     = ~write_q;
                tmo_d    = '0;
                state_d  = S_DATA;
            end
            S_DATA: begin
                ad_oe_d  = write_q;
                ad_out_d = write_q ? wdata_q : '0;
                ds_n_d   = 1'b0;
                rw_d     = ~write_q;
                if (!dtack_s) begin
                    error_d = 1'b0;
                    rdata_d = write_q ? '0 : ad_in_q;
                    state_d = S_DONE;
                end else if ((TIMEOUT_CYCLES != 0) && (tmo_q == TMO_LAST)) begin
                    error_d = 1'b1;
                    rdata_d = '0;
                    state_d = S_DONE;
                end else begin
                    tmo_d = tmo_q + CW'(1);
                end
            end
            S_DONE: begin
                resp_valid = 1'b1;
                ad_oe_d    = write_q;
                ad_out_d   = write_q ? wdata_q : '0;
                rw_d       = ~write_q;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            beat_q       <= '0;
            tmo_q        <= '0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            error_q      <= 1'b0;
            rdata_q      <= '0;
            dtack_sync_q <= 2'b11;
            ad_out_q     <= '0;
            ad_in_q      <= '0;
            ad_oe_q      <= 1'b0;
            ale_q        <= 1'b0;
            ds_n_q       <= 1'b1;
            rw_q         <= 1'b1;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            tmo_q        <= tmo_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            error_q      <= error_d;
            rdata_q      <= rdata_d;
            dtack_sync_q <= dtack_sync_d;
            ad_out_q     <= ad_out_d;
            ad_in_q      <= ad_in_d;
            ad_oe_q      <= ad_oe_d;
            ale_q        <= ale_d;
            ds_n_q       <= ds_n_d;
            rw_q         <= rw_d;
        end
    end

endmodule
